epp_bram_responder: RTL
=======================

Name: epp_bram_responder

Overview:
- Device-side EPP responder for the wac board FPGA.
- Services host address/data cycles (strobe plus wait handshake) and moves bytes into and out of the 4K x 8 BRAM through an auto-incrementing pointer.
- Sits between the parallel-port pins and the BRAM port that wac_top exposes as busBramAddr/busBramIn/busBramOut.
- Owns the host side of the same strobe/data-bus exchange the board test fixtures drive.

Parameters:
- ADDR_W, 12: BRAM pointer width; wraps modulo 2^ADDR_W.
- SYNC_STAGES, 2: flip-flop stages on eppDataStb, eppAddrStb and eppWrite.
- TIMEOUT_CYC, 255: wait-release timeout in clk cycles; used only with EPP_TIMEOUT_EN.

Ports:
- clk, input, 1: system clock. All logic is rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- eppDataStb, input, 1: active-low data strobe from host, asynchronous.
- eppAddrStb, input, 1: active-low address strobe from host, asynchronous.
- eppWrite, input, 1: low = host write, high = host read.
- eppDataIn, input, 8: host data bus in.
- eppDataOut, output, 8: data returned to host.
- eppDataOe, output, 1: drive enable for the external bus tristate.
- eppWait, output, 1: handshake to host; high = cycle accepted.
- busBramAddr, output, ADDR_W: BRAM address (the pointer).
- busBramDout, output, 8: write data to BRAM.
- busBramWe, output, 1: one-cycle BRAM write enable.
- busBramDin, input, 8: BRAM read data, 1-cycle read latency.

Behaviour:
- Clock/reset: one clock, clk; rst is asynchronous and active-high.
  - Reset takes effect immediately, including mid-cycle.
  - Reset values: all outputs 0; pointer 0; selected register 0; status flags 0; FSM IDLE.
- Synchronisers: strobes and eppWrite pass through SYNC_STAGES flip-flops. A falling edge is detected when the synced value goes 1 to 0; call the detect cycle E.
- Registers, selected by the low 2 bits of an address-write byte:
  - 0, PTR_LO: pointer bits 7:0.
  - 1, PTR_HI: pointer bits 11:8, from data bits 3:0. Upper bits read as 0.
  - 2, DATA: BRAM access with pointer auto-increment.
  - 3, STATUS, read-only: bit0 = wrap, bit1 = timeout. Reading STATUS clears both flags; writes are ignored.
- FSM states: IDLE, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, RD_LATCH, WAIT_REL.
- Address write: at E, eppDataIn is sampled into the register select. eppWait = 1 from E+1.
- Address read: eppDataOut = {6'b0, sel} at E+1; eppWait = 1 from E+1.
- Data write:
  - At E, eppDataIn is captured.
  - At E+1: busBramWe = 1 for exactly one cycle, busBramDout = captured byte, busBramAddr = pointer; eppWait = 1.
  - For registers 0, 1 and 3 no BRAM write occurs; the register is updated at E+1.
- Data read from DATA:
  - busBramAddr = pointer at E.
  - busBramDin is latched to eppDataOut at E+1 (RD_LATCH).
  - eppWait = 1 from E+2.
  - Other registers return their value, also with eppWait from E+2.
- eppDataOe = 1 from E until release for read cycles only; always 0 for writes.
- WAIT_REL:
  - Holds eppWait = 1 until the active synced strobe returns high.
  - eppWait drops the cycle after release, then the FSM returns to IDLE.
  - For DATA cycles the pointer increments on the release cycle.
- Pointer wrap: an increment from 2^ADDR_W-1 goes to 0 and sets the wrap flag, which is sticky.
- Simultaneous strobes: if both fall in the same cycle, the address strobe wins. The data strobe is ignored until both are high.
- Strobes seen outside IDLE are ignored. A new cycle needs the strobe synced high for at least one cycle after IDLE is reached.
- The host must keep data stable while its strobe is low; host strobe low time is bounded by our eppWait.

Optional Feature:
- Macro: EPP_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_REL.
  - If the strobe is still low after TIMEOUT_CYC cycles: eppWait and eppDataOe drop, timeout flag is set, FSM goes to IDLE.
  - The pointer does not increment on a timed-out cycle.
  - The still-low strobe is not re-detected until it goes high.
- Not defined: WAIT_REL waits indefinitely; STATUS bit1 always reads 0.

Test Plan:
- Reset: rst high asynchronously mid-DATA_WR with eppWait=1 -> eppWait, busBramWe, eppDataOe and busBramAddr are 0 in the same timestep; the next cycle starts from IDLE.
- Pointer set and burst write:
  - Stimulus: addr-write 0x00, data 0x03; addr-write 0x01, data 0x00; addr-write 0x02; data writes 0x55, 0x01, 0xAA.
  - Required: BRAM writes 0x55@0x003, 0x01@0x004, 0xAA@0x005, each a single-cycle busBramWe; final pointer 0x006; eppWait rises once per strobe and drops 1 cycle after release.
- Read-back: pointer = 0x003, three DATA reads -> eppDataOut = 0x55, 0x01, 0xAA; eppWait rises at E+2; eppDataOe high only during the strobes.
- Wrap: pointer = 0xFFF, write 0x11 -> 0x11@0xFFF, pointer 0x000, STATUS reads 0x01; a second STATUS read returns 0x00.
- Strobe collision: eppAddrStb and eppDataStb fall in the same clk with eppDataIn 0x02 -> select becomes 2, no BRAM write, no pointer change.
- EPP_TIMEOUT_EN, TIMEOUT_CYC=8: hold eppDataStb low 50 cycles on a DATA write -> eppWait drops after 8 cycles in WAIT_REL, pointer unchanged, STATUS reads 0x02.

Source files
------------

// File: rtl/epp_bram_responder_if.sv
// rtl/epp_bram_responder_if.sv - EPP host pins plus BRAM port bundle for epp_bram_responder
//
// Signals:
//   eppDataStb, eppAddrStb : active-low host strobes (asynchronous to clk)
//   eppWrite               : 0 = host write, 1 = host read
//   eppDataIn/eppDataOut   : host data bus, in and out
//   eppDataOe              : drive enable for the external tristate
//   eppWait                : handshake back to host, 1 = cycle accepted
//   busBramAddr            : BRAM address (auto-incrementing pointer)
//   busBramDout/busBramWe  : BRAM write data and one-cycle write enable
//   busBramDin             : BRAM read data, one cycle after the address
// Modports: master = host pins plus BRAM model side, slave = responder.
interface epp_bram_responder_if #(
    parameter int ADDR_W = 12
);
    logic              eppDataStb;
    logic              eppAddrStb;
    logic              eppWrite;
    logic [7:0]        eppDataIn;
    logic [7:0]        eppDataOut;
    logic              eppDataOe;
    logic              eppWait;
    logic [ADDR_W-1:0] busBramAddr;
    logic [7:0]        busBramDout;
    logic              busBramWe;
    logic [7:0]        busBramDin;

    modport master (
        output eppDataStb, eppAddrStb, eppWrite, eppDataIn, busBramDin,
        input  eppDataOut, eppDataOe, eppWait, busBramAddr, busBramDout, busBramWe
    );

    modport slave (
        input  eppDataStb, eppAddrStb, eppWrite, eppDataIn, busBramDin,
        output eppDataOut, eppDataOe, eppWait, busBramAddr, busBramDout, busBramWe
    );
endinterface

// File: rtl/epp_bram_responder.sv
// rtl/epp_bram_responder.sv - EPP device-side responder moving bytes to/from a 4K x 8 BRAM
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : epp_bram_responder_if.slave (EPP host pins and BRAM port)
// Registers (selected by the low two bits of an address write):
//   0 PTR_LO, 1 PTR_HI, 2 DATA (BRAM access, pointer auto-increment),
//   3 STATUS (read-only, bit0 wrap, bit1 timeout, cleared on read)
// Optional feature macro: EPP_TIMEOUT_EN (wait-release timeout of TIMEOUT_CYC cycles).
module epp_bram_responder #(
    parameter int ADDR_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    epp_bram_responder_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, RD_LATCH, WAIT_REL
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] ds_sync, as_sync, wr_sync;
    logic ds_s, as_s, wr_s;
    logic ds_prev, as_prev, idle_prev;
    logic addr_fall, data_fall;

    logic [1:0]        sel;
    logic [7:0]        data_q;
    logic [7:0]        dout_q;
    logic [ADDR_W-1:0] ptr;
    logic              wrap, tmo;
    logic              cyc_read, cyc_data;
    logic              strobe_s, release_c, timed_out;

    assign ds_s = ds_sync[SYNC_STAGES-1];
    assign as_s = as_sync[SYNC_STAGES-1];
    assign wr_s = wr_sync[SYNC_STAGES-1];

    // A fall only counts if the strobe was seen high while already idle, so a
    // strobe still low from the previous cycle (or a timeout) is never re-detected.
    // The address strobe wins a tie; the data strobe waits until both are high.
    assign addr_fall = idle_prev & as_prev & ~as_s;
    assign data_fall = idle_prev & ds_prev & ~ds_s & as_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ds_sync   <= '1;
            as_sync   <= '1;
            wr_sync   <= '1;
            ds_prev   <= 1'b1;
            as_prev   <= 1'b1;
            idle_prev <= 1'b1;
        end else begin
            ds_sync   <= (ds_sync << 1) | SYNC_STAGES'(bus.eppDataStb);
            as_sync   <= (as_sync << 1) | SYNC_STAGES'(bus.eppAddrStb);
            wr_sync   <= (wr_sync << 1) | SYNC_STAGES'(bus.eppWrite);
            ds_prev   <= ds_s;
            as_prev   <= as_s;
            idle_prev <= (state == IDLE);
        end
    end

`ifdef EPP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == WAIT_REL)
            cnt <= cnt + CNT_W'(1);
        else
            cnt <= '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        release_c = 1'b0;
        timed_out = 1'b0;
        strobe_s  = cyc_data ? ds_s : as_s;
        case (state)
            IDLE: begin
                if (addr_fall)
                    state_n = wr_s ? ADDR_RD : ADDR_WR;
                else if (data_fall)
                    state_n = wr_s ? RD_LATCH : DATA_WR;
            end
            ADDR_WR, ADDR_RD, DATA_WR, DATA_RD: state_n = WAIT_REL;
            RD_LATCH: state_n = DATA_RD;
            WAIT_REL: begin
                if (strobe_s) begin
                    release_c = 1'b1;
                    state_n   = IDLE;
                end
`ifdef EPP_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timed_out = 1'b1;
                    state_n   = IDLE;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            data_q   <= '0;
            dout_q   <= '0;
            ptr      <= '0;
            wrap     <= 1'b0;
            tmo      <= 1'b0;
            cyc_read <= 1'b0;
            cyc_data <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (addr_fall) begin
                        cyc_data <= 1'b0;
                        cyc_read <= wr_s;
                        if (wr_s)
                            dout_q <= {6'b0, sel};
                        else
                            sel <= bus.eppDataIn[1:0];
                    end else if (data_fall) begin
                        cyc_data <= 1'b1;
                        cyc_read <= wr_s;
                        data_q   <= bus.eppDataIn;
                    end
                end
                DATA_WR: begin
                    case (sel)
                        2'd0:    ptr <= {ptr[ADDR_W-1:8], data_q};
                        2'd1:    ptr <= ADDR_W'({data_q, ptr[7:0]});
                        default: ;
                    endcase
                end
                RD_LATCH: begin
                    case (sel)
                        2'd0: dout_q <= ptr[7:0];
                        2'd1: dout_q <= 8'(ptr >> 8);
                        2'd2: dout_q <= bus.busBramDin;
                        default: begin
                            dout_q <= {6'b0, tmo, wrap};
                            wrap   <= 1'b0;
                            tmo    <= 1'b0;
                        end
                    endcase
                end
                WAIT_REL: begin
                    if (release_c && cyc_data && (sel == 2'd2)) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (&ptr)
                            wrap <= 1'b1;
                    end
                    if (timed_out)
                        tmo <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state so an asynchronous reset clears them at once.
    assign bus.eppWait     = (state != IDLE) && (state != RD_LATCH);
    assign bus.eppDataOe   = ((state == IDLE) && (addr_fall || data_fall) && wr_s)
                           || (state == ADDR_RD) || (state == RD_LATCH) || (state == DATA_RD)
                           || ((state == WAIT_REL) && cyc_read);
    assign bus.eppDataOut  = dout_q;
    assign bus.busBramAddr = ptr;
    assign bus.busBramDout = data_q;
    assign bus.busBramWe   = (state == DATA_WR) && (sel == 2'd2);
endmodule
